unidade_controle_jogo: RTL and testbench

//  Moore FSM sequencing the memory-game datapath (fluxo_dados): per round it shows ROM

---
 rtl/unidade_controle_jogo_if.sv | 42 ++++
 rtl/unidade_controle_jogo.sv | 154 +++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_jogo_if.sv
// Status/control bundle between the memory-game controller and its datapath (fluxo_dados).
// The controller takes the master view; the datapath (or a bench) takes the slave view.
interface unidade_controle_jogo_if;
    // datapath status towards the controller
    logic       iniciar;
    logic       fimM;
    logic       fimL;
    logic       endecoIgualLimite;
    logic       jogada_feita;
    logic       botoesIgualMemoria;
    logic       timeout;
    // controller commands towards the datapath
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraM;
    logic       contaM;
    logic       zeraR;
    logic       registraR;
    logic       contaT;
    logic [1:0] seletor;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       perdeu_tempo;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, fimM, fimL, endecoIgualLimite, jogada_feita,
               botoesIgualMemoria, timeout,
        output zeraE, contaE, zeraL, contaL, zeraM, contaM, zeraR, registraR,
               contaT, seletor, pronto, acertou, errou, perdeu_tempo, db_estado
    );

    modport slave (
        output iniciar, fimM, fimL, endecoIgualLimite, jogada_feita,
               botoesIgualMemoria, timeout,
        input  zeraE, contaE, zeraL, contaL, zeraM, contaM, zeraR, registraR,
               contaT, seletor, pronto, acertou, errou, perdeu_tempo, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Moore controller for the memory game: shows items 0..limit, then collects and checks plays.
// Optional play timeout enabled by defining JOGO_TIMEOUT_EN.
module unidade_controle_jogo #(
    parameter bit MOSTRA_APAGA = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    unidade_controle_jogo_if.master      ctl
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        INICIO_RODADA  = 4'd2,
        MOSTRA         = 4'd3,
        APAGA          = 4'd4,
        PROX_MOSTRA    = 4'd5,
        INICIA_JOGADAS = 4'd6,
        ESPERA         = 4'd7,
        REGISTRA       = 4'd8,
        COMPARA        = 4'd9,
        PROX_JOGADA    = 4'd10,
        PROX_RODADA    = 4'd11,
        ACERTOU_ST     = 4'd12,
        ERROU_ST       = 4'd13,
        TIMEOUT_ST     = 4'd14
    } estado_t;

    estado_t estado_reg;
    estado_t estado_next;
    logic    timeout_evt;

`ifdef JOGO_TIMEOUT_EN
    assign timeout_evt = ctl.timeout;
`else
    // Without the timeout feature the input is deliberately left unconsumed.
    logic unused_timeout;
    assign unused_timeout = ctl.timeout;
    assign timeout_evt    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next = INICIAL;
        case (estado_reg)
            INICIAL:        estado_next = ctl.iniciar ? PREPARA : INICIAL;
            PREPARA:        estado_next = INICIO_RODADA;
            INICIO_RODADA:  estado_next = MOSTRA;
            MOSTRA: begin
                if (!ctl.fimM)        estado_next = MOSTRA;
                else if (MOSTRA_APAGA) estado_next = APAGA;
                else                  estado_next = PROX_MOSTRA;
            end
            APAGA:          estado_next = ctl.fimM ? PROX_MOSTRA : APAGA;
            PROX_MOSTRA:    estado_next = ctl.endecoIgualLimite ? INICIA_JOGADAS : MOSTRA;
            INICIA_JOGADAS: estado_next = ESPERA;
            ESPERA: begin
                // a play arriving together with the timeout still counts
                if (ctl.jogada_feita)  estado_next = REGISTRA;
                else if (timeout_evt)  estado_next = TIMEOUT_ST;
                else                   estado_next = ESPERA;
            end
            REGISTRA:       estado_next = COMPARA;
            COMPARA: begin
                if (!ctl.botoesIgualMemoria)     estado_next = ERROU_ST;
                else if (!ctl.endecoIgualLimite) estado_next = PROX_JOGADA;
                else if (ctl.fimL)               estado_next = ACERTOU_ST;
                else                             estado_next = PROX_RODADA;
            end
            PROX_JOGADA:    estado_next = ESPERA;
            PROX_RODADA:    estado_next = INICIO_RODADA;
            ACERTOU_ST:     estado_next = ctl.iniciar ? PREPARA : ACERTOU_ST;
            ERROU_ST:       estado_next = ctl.iniciar ? PREPARA : ERROU_ST;
            TIMEOUT_ST:     estado_next = ctl.iniciar ? PREPARA : TIMEOUT_ST;
            default:        estado_next = INICIAL;
        endcase
    end

    // Pure state decode; the unused code 15 falls through to all-zero.
    always_comb begin
        ctl.zeraE        = 1'b0;
        ctl.contaE       = 1'b0;
        ctl.zeraL        = 1'b0;
        ctl.contaL       = 1'b0;
        ctl.zeraM        = 1'b0;
        ctl.contaM       = 1'b0;
        ctl.zeraR        = 1'b0;
        ctl.registraR    = 1'b0;
        ctl.contaT       = 1'b0;
        ctl.seletor      = 2'd0;
        ctl.pronto       = 1'b0;
        ctl.acertou      = 1'b0;
        ctl.errou        = 1'b0;
        ctl.perdeu_tempo = 1'b0;
        case (estado_reg)
            PREPARA: begin
                ctl.zeraE = 1'b1;
                ctl.zeraL = 1'b1;
                ctl.zeraR = 1'b1;
                ctl.zeraM = 1'b1;
            end
            INICIO_RODADA: begin
                ctl.zeraE = 1'b1;
                ctl.zeraM = 1'b1;
            end
            MOSTRA: begin
                ctl.seletor = 2'd1;
                ctl.contaM  = 1'b1;
            end
            APAGA:          ctl.contaM = 1'b1;
            PROX_MOSTRA: begin
                // stepping past the limit is harmless: INICIA_JOGADAS clears the address
                ctl.zeraM  = 1'b1;
                ctl.contaE = 1'b1;
            end
            INICIA_JOGADAS: begin
                ctl.zeraE = 1'b1;
                ctl.zeraR = 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
            ESPERA:         ctl.contaT = 1'b1;
`endif
            REGISTRA:       ctl.registraR = 1'b1;
            COMPARA:        ctl.seletor   = 2'd2;
            PROX_JOGADA:    ctl.contaE    = 1'b1;
            PROX_RODADA:    ctl.contaL    = 1'b1;
            ACERTOU_ST: begin
                ctl.pronto  = 1'b1;
                ctl.acertou = 1'b1;
            end
            ERROU_ST: begin
                ctl.pronto = 1'b1;
                ctl.errou  = 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
            TIMEOUT_ST: begin
                ctl.pronto       = 1'b1;
                ctl.perdeu_tempo = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ctl.db_estado = estado_reg;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: two instances (with and without the blank interval) run
// against a state-table reference; directed sequences pin the reference, then random play.
module tb_unidade_controle_jogo;

`ifdef JOGO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic iniciar = 0, fimM = 0, fimL = 0, endeco = 0, jogada = 0, igual = 0, timeout = 0;

    int vectors = 0;
    int miscompares = 0;
    int model_a = 0;   // reference state code, blank-interval instance
    int model_b = 0;   // reference state code, no-blank instance

    always #5 clock = ~clock;

    unidade_controle_jogo_if if_a ();
    unidade_controle_jogo_if if_b ();

    assign if_a.iniciar = iniciar;            assign if_b.iniciar = iniciar;
    assign if_a.fimM = fimM;                  assign if_b.fimM = fimM;
    assign if_a.fimL = fimL;                  assign if_b.fimL = fimL;
    assign if_a.endecoIgualLimite = endeco;   assign if_b.endecoIgualLimite = endeco;
    assign if_a.jogada_feita = jogada;        assign if_b.jogada_feita = jogada;
    assign if_a.botoesIgualMemoria = igual;   assign if_b.botoesIgualMemoria = igual;
    assign if_a.timeout = timeout;            assign if_b.timeout = timeout;

    unidade_controle_jogo #(.MOSTRA_APAGA(1'b1)) dut_a (.clock(clock), .reset_n(reset_n), .ctl(if_a));
    unidade_controle_jogo #(.MOSTRA_APAGA(1'b0)) dut_b (.clock(clock), .reset_n(reset_n), .ctl(if_b));

    // Game rules as a transition table over state codes.
    function automatic int proximo(int s, bit apaga);
        case (s)
            0:  return iniciar ? 1 : 0;
            1:  return 2;
            2:  return 3;
            3:  return fimM ? (apaga ? 4 : 5) : 3;
            4:  return fimM ? 5 : 4;
            5:  return endeco ? 6 : 3;
            6:  return 7;
            7:  return jogada ? 8 : ((TO_EN && timeout) ? 14 : 7);
            8:  return 9;
            9:  return !igual ? 13 : (!endeco ? 10 : (fimL ? 12 : 11));
            10: return 7;
            11: return 2;
            12, 13, 14: return iniciar ? 1 : s;
            default: return 0;
        endcase
    endfunction

    // Expected outputs {zE,cE,zL,cL,zM,cM,zR,rR,cT,sel[1:0],pronto,acertou,errou,perdeu,estado[3:0]}.
    function automatic logic [18:0] esperado(int s);
        logic [14:0] c;
        logic [3:0]  code;
        c = '0;
        code = s[3:0];
        case (s)
            1:  c = 15'b101010100_00_0000;
            2:  c = 15'b100010000_00_0000;
            3:  c = 15'b000001000_01_0000;
            4:  c = 15'b000001000_00_0000;
            5:  c = 15'b010010000_00_0000;
            6:  c = 15'b100000100_00_0000;
            7:  c = {8'b0, TO_EN, 6'b0};
            8:  c = 15'b000000010_00_0000;
            9:  c = 15'b000000000_10_0000;
            10: c = 15'b010000000_00_0000;
            11: c = 15'b000100000_00_0000;
            12: c = 15'b000000000_00_1100;
            13: c = 15'b000000000_00_1010;
            14: c = 15'b000000000_00_1001;
            default: c = '0;
        endcase
        return {c, code};
    endfunction

    function automatic logic [18:0] pack_a();
        return {if_a.zeraE, if_a.contaE, if_a.zeraL, if_a.contaL, if_a.zeraM, if_a.contaM,
                if_a.zeraR, if_a.registraR, if_a.contaT, if_a.seletor, if_a.pronto,
                if_a.acertou, if_a.errou, if_a.perdeu_tempo, if_a.db_estado};
    endfunction

    function automatic logic [18:0] pack_b();
        return {if_b.zeraE, if_b.contaE, if_b.zeraL, if_b.contaL, if_b.zeraM, if_b.contaM,
                if_b.zeraR, if_b.registraR, if_b.contaT, if_b.seletor, if_b.pronto,
                if_b.acertou, if_b.errou, if_b.perdeu_tempo, if_b.db_estado};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            model_a <= 0;
            model_b <= 0;
        end else begin
            model_a <= proximo(model_a, 1'b1);
            model_b <= proximo(model_b, 1'b0);
        end
    end

    // Every-cycle comparison against the reference, away from the active edge.
    always @(negedge clock) begin
        logic [18:0] ea, eb, aa, ab;
        ea = esperado(model_a);
        eb = esperado(model_b);
        aa = pack_a();
        ab = pack_b();
        vectors += 2;
        if (aa !== ea) begin
            miscompares++;
            $display("FAIL outputs_apaga t=%0t got=%b expected=%b", $time, aa, ea);
        end
        if (ab !== eb) begin
            miscompares++;
            $display("FAIL outputs_sem_apaga t=%0t got=%b expected=%b", $time, ab, eb);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
        end else begin
            $display("ok   %s t=%0t value=%0d", name, $time, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    int seq_a[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 2};
    int seq_b[11] = '{1, 2, 3, 5, 6, 7, 8, 9, 11, 2, 3};

    initial begin
        tick();
        tick();
        chk("reset_estado_a", int'(if_a.db_estado), 0);
        chk("reset_pronto_a", int'(if_a.pronto), 0);
        reset_n = 1'b1;
        tick();
        chk("idle_estado_a", int'(if_a.db_estado), 0);

        // One full round at limit 0 with every status asserted.
        iniciar = 1; fimM = 1; endeco = 1; jogada = 1; igual = 1; fimL = 0; timeout = 0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("rodada_a[%0d]", i), int'(if_a.db_estado), seq_a[i]);
            chk($sformatf("rodada_b[%0d]", i), int'(if_b.db_estado), seq_b[i]);
            chk($sformatf("contaL_a[%0d]", i), int'(if_a.contaL), (seq_a[i] == 11) ? 1 : 0);
            #1;
            iniciar = 0;
        end

        // No play while the wait counter expires.
        jogada = 0; timeout = 1;
        repeat (10) tick();
        chk("espera_timeout_a", int'(if_a.db_estado), TO_EN ? 14 : 7);
        chk("espera_timeout_b", int'(if_b.db_estado), TO_EN ? 14 : 7);
        chk("perdeu_tempo_a", int'(if_a.perdeu_tempo), TO_EN ? 1 : 0);

        // Simultaneous play and timeout, then a wrong play.
        jogada = 1; igual = 0;
        tick();
        chk("empate_a", int'(if_a.db_estado), TO_EN ? 14 : 8);
        jogada = 0; timeout = 0;
        repeat (2) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("fim_estado_a", int'(if_a.db_estado), TO_EN ? 14 : 13);
            chk("fim_errou_a", int'(if_a.errou), TO_EN ? 0 : 1);
            chk("fim_pronto_b", int'(if_b.pronto), 1);
        end

        // Restart, stall in MOSTRA, then asynchronous reset.
        iniciar = 1; fimM = 0; igual = 1;
        tick();
        chk("reinicio_a", int'(if_a.db_estado), 1);
        iniciar = 0;
        repeat (3) tick();
        chk("mostra_a", int'(if_a.db_estado), 3);
        chk("mostra_sel_a", int'(if_a.seletor), 1);
        reset_n = 0;
        #1;
        chk("reset_async_a", int'(pack_a()), 0);
        chk("reset_async_b", int'(pack_b()), 0);
        #1;
        reset_n = 1;
        tick();

        // Randomized play against the reference.
        for (int n = 0; n < 3000; n++) begin
            iniciar = ($urandom_range(0, 7) == 0);
            fimM    = ($urandom_range(0, 2) == 0);
            fimL    = ($urandom_range(0, 3) == 0);
            endeco  = ($urandom_range(0, 2) == 0);
            jogada  = ($urandom_range(0, 3) == 0);
            igual   = ($urandom_range(0, 7) != 0);
            timeout = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 0;
                #1;
                chk("reset_aleatorio_a", int'(if_a.db_estado), 0);
                reset_n = 1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
